// File: rtl/matrix_stamp_accumulator.sv
// Read-modify-write engine adding MNA stamps into the matrix RAM through an
// external FP adder, with RAW hazard stalls, ground-stamp dropping and region clear.
module matrix_stamp_accumulator #(
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 6,
    parameter int ROW_STRIDE = 64,
    parameter int ADDR_W     = 12,
    parameter int RAM_LAT    = 1,
    parameter int ADD_LAT    = 7
) (
    input  logic              clk,
    input  logic              program_resetn,
    input  logic              clear_start,
    input  logic [IDX_W-1:0]  clear_rows,
    input  logic [IDX_W-1:0]  clear_cols,
    output logic              clear_done,
    input  logic              stamp_valid,
    output logic              stamp_ready,
    input  logic [IDX_W-1:0]  stamp_row,
    input  logic [IDX_W-1:0]  stamp_col,
    input  logic [DATA_W-1:0] stamp_value,
    input  logic              stamp_negate,
    input  logic [IDX_W-1:0]  ground_node,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              busy,
    output logic [7:0]        skipped_count,
    output logic [ADDR_W-1:0] matrix_addr_a,
    output logic [ADDR_W-1:0] matrix_addr_b,
    output logic [DATA_W-1:0] matrix_data_b,
    output logic              matrix_wren_b,
    input  logic [DATA_W-1:0] matrix_out_a,
    output logic [DATA_W-1:0] adder_data_a,
    output logic [DATA_W-1:0] adder_data_b,
    input  logic [DATA_W-1:0] adder_out
);
    localparam int T      = RAM_LAT + ADD_LAT;
    localparam int STAGES = T - 1;

    typedef enum logic [1:0] {IDLE, CLEAR, FLUSH} state_t;

    state_t                          state;
    logic [STAGES:0]                 vld_pipe;
    logic [STAGES:0][ADDR_W-1:0]     addr_pipe;
    logic [RAM_LAT-1:0][DATA_W-1:0]  val_pipe;
    logic [IDX_W-1:0]                clr_row, clr_col, clr_rows_q, clr_cols_q;

    logic [ADDR_W-1:0] stamp_addr, clr_addr;
    logic [DATA_W-1:0] signed_value;
    logic              is_ground, hazard, slot_open, fire, skip, pipe_empty, drained;

    assign stamp_addr   = ADDR_W'(stamp_row) * ADDR_W'(ROW_STRIDE) + ADDR_W'(stamp_col);
    assign clr_addr     = ADDR_W'(clr_row) * ADDR_W'(ROW_STRIDE) + ADDR_W'(clr_col);
    assign signed_value = stamp_value ^ {stamp_negate, {(DATA_W-1){1'b0}}};
    assign is_ground    = (stamp_row == ground_node) || (stamp_col == ground_node);

    // The stage being written this cycle still counts: a same-cycle read returns old data.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i <= STAGES; i++)
            if (vld_pipe[i] && addr_pipe[i] == stamp_addr) hazard = 1'b1;
    end

    assign slot_open   = program_resetn && state == IDLE && !clear_start && !flush_req;
    assign stamp_ready = slot_open && (is_ground || !hazard);
    assign fire        = stamp_valid && stamp_ready && !is_ground;
    assign skip        = stamp_valid && stamp_ready && is_ground;
    assign pipe_empty  = vld_pipe == '0;
    // Only the write stage may still be occupied: nothing in flight next cycle.
    assign drained     = vld_pipe[STAGES-1:0] == '0;
    assign busy        = state != IDLE || !pipe_empty;

    assign matrix_addr_a = fire ? stamp_addr : '0;
    assign adder_data_a  = vld_pipe[RAM_LAT-1] ? matrix_out_a : '0;
    assign adder_data_b  = vld_pipe[RAM_LAT-1] ? val_pipe[RAM_LAT-1] : '0;

    // CLEAR is entered only with an empty pipeline and blocks new stamps, so port B never collides.
    always_comb begin
        matrix_wren_b = 1'b0;
        matrix_addr_b = '0;
        matrix_data_b = '0;
        if (state == CLEAR) begin
            matrix_wren_b = 1'b1;
            matrix_addr_b = clr_addr;
        end else if (vld_pipe[STAGES]) begin
            matrix_wren_b = 1'b1;
            matrix_addr_b = addr_pipe[STAGES];
            matrix_data_b = adder_out;
        end
    end

    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            val_pipe  <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[STAGES-1:0], fire};
            addr_pipe   <= {addr_pipe[STAGES-1:0], stamp_addr};
            val_pipe[0] <= signed_value;
            for (int i = 1; i < RAM_LAT; i++) val_pipe[i] <= val_pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) skipped_count <= '0;
        else if (skip && skipped_count != 8'hFF) skipped_count <= skipped_count + 8'd1;
    end

    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            state      <= IDLE;
            clear_done <= 1'b0;
            flush_done <= 1'b0;
            clr_row    <= '0;
            clr_col    <= '0;
            clr_rows_q <= '0;
            clr_cols_q <= '0;
        end else begin
            clear_done <= 1'b0;
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start && pipe_empty) begin
                        if (clear_rows == '0 || clear_cols == '0) begin
                            clear_done <= 1'b1;
                        end else begin
                            state      <= CLEAR;
                            clr_rows_q <= clear_rows;
                            clr_cols_q <= clear_cols;
                            clr_row    <= '0;
                            clr_col    <= '0;
                        end
                    end else if (flush_req) begin
                        state <= FLUSH;
                    end
                end
                CLEAR: begin
                    if (clr_col == clr_cols_q - 1'b1) begin
                        clr_col <= '0;
                        if (clr_row == clr_rows_q - 1'b1) begin
                            clear_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            clr_row <= clr_row + 1'b1;
                        end
                    end else begin
                        clr_col <= clr_col + 1'b1;
                    end
                end
                FLUSH: begin
                    if (drained) begin
                        flush_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_stamp_accumulator.sv
// Bench for matrix_stamp_accumulator: RAM and adder models, directed sequences,
// a vector table and a randomized run checked against an arithmetic reference.
module tb_matrix_stamp_accumulator;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        program_resetn;
    logic        clear_start, clear_done, stamp_valid, stamp_ready, stamp_negate;
    logic [5:0]  clear_rows, clear_cols, stamp_row, stamp_col, ground_node;
    logic [31:0] stamp_value, matrix_data_b, matrix_out_a, adder_data_a, adder_data_b, adder_out;
    logic        flush_req, flush_done, busy, matrix_wren_b;
    logic [7:0]  skipped_count;
    logic [11:0] matrix_addr_a, matrix_addr_b;

    matrix_stamp_accumulator dut (
        .clk(clk), .program_resetn(program_resetn),
        .clear_start(clear_start), .clear_rows(clear_rows), .clear_cols(clear_cols),
        .clear_done(clear_done), .stamp_valid(stamp_valid), .stamp_ready(stamp_ready),
        .stamp_row(stamp_row), .stamp_col(stamp_col), .stamp_value(stamp_value),
        .stamp_negate(stamp_negate), .ground_node(ground_node), .flush_req(flush_req),
        .flush_done(flush_done), .busy(busy), .skipped_count(skipped_count),
        .matrix_addr_a(matrix_addr_a), .matrix_addr_b(matrix_addr_b),
        .matrix_data_b(matrix_data_b), .matrix_wren_b(matrix_wren_b),
        .matrix_out_a(matrix_out_a), .adder_data_a(adder_data_a),
        .adder_data_b(adder_data_b), .adder_out(adder_out)
    );

    always #5 clk = ~clk;

    function automatic real f2r(logic [31:0] b);
        int  e = int'(b[30:23]);
        real m;
        if (e == 0) return 0.0;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic s = r < 0.0;
        real  a = s ? -r : r;
        int   e = 127;
        if (a == 0.0) return 32'h0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((a - 1.0) * 8388608.0))};
    endfunction

    // Environment: synchronous RAM (read-old-data) and a 7-deep adder.
    logic [31:0] mem [0:4095];
    logic [31:0] add_pipe [0:6];
    always @(posedge clk) begin
        if (matrix_wren_b) mem[matrix_addr_b] <= matrix_data_b;
        matrix_out_a <= mem[matrix_addr_a];
        add_pipe[0]  <= r2f(f2r(adder_data_a) + f2r(adder_data_b));
        for (int i = 1; i < 7; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign adder_out = add_pipe[6];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          cd_cnt = 0, fd_cnt = 0, cd_cyc = 0, fd_cyc = 0, busy_err = 0;
    int          wr_cyc_q[$];
    logic [11:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    always @(negedge clk) begin
        if (matrix_wren_b) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(matrix_addr_b);
            wr_data_q.push_back(matrix_data_b);
            if (!busy) busy_err++;
        end
        if (clear_done) begin cd_cnt++; cd_cyc = cyc; end
        if (flush_done) begin fd_cnt++; fd_cyc = cyc; end
    end

    int n_pass = 0, n_tot = 0, exp_skip = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clr_log();
        wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    endtask

    task automatic offer(input int r, input int c, input logic [31:0] v, input logic neg,
                         output int waited, output int acc_cyc);
        stamp_row = 6'(r); stamp_col = 6'(c); stamp_value = v; stamp_negate = neg;
        stamp_valid = 1'b1;
        #1;
        waited = 0;
        while (!stamp_ready && waited < 40) begin @(negedge clk); #2; waited++; end
        if (!stamp_ready) begin n_tot++; $display("FAIL offer_timeout: row %0d col %0d never ready", r, c); end
        acc_cyc = cyc;
        @(negedge clk); #2;
        stamp_valid = 1'b0;
    endtask

    task automatic do_flush();
        int f0 = fd_cnt;
        flush_req = 1'b1;
        @(negedge clk); #2;
        flush_req = 1'b0;
        for (int k = 0; k < 60 && fd_cnt == f0; k++) begin @(negedge clk); #2; end
        if (fd_cnt == f0) begin n_tot++; $display("FAIL flush_timeout: flush_done never seen"); end
    endtask

    task automatic do_clear(input int rows, input int cols, output int start_cyc);
        int c0 = cd_cnt;
        clear_rows = 6'(rows); clear_cols = 6'(cols); clear_start = 1'b1;
        start_cyc = cyc;
        @(negedge clk); #2;
        clear_start = 1'b0;
        for (int k = 0; k < 300 && cd_cnt == c0; k++) begin @(negedge clk); #2; end
        if (cd_cnt == c0) begin n_tot++; $display("FAIL clear_timeout: clear_done never seen"); end
    endtask

    typedef struct {
        int row; int col; logic [31:0] val; logic neg; int gnd; logic [31:0] exp; int skip;
    } vec_t;
    vec_t vt[7];

    real ref_m [0:63];
    int  w, a, s, cd0, k;
    int  acc[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{5, 6, 32'h3F800000, 1'b0, 63, 32'h3F800000, 0};
        vt[1] = '{5, 6, 32'h40400000, 1'b1, 63, 32'hC0000000, 0};
        vt[2] = '{5, 6, 32'h40800000, 1'b0,  6, 32'hC0000000, 1};
        vt[3] = '{5, 6, 32'h40800000, 1'b0,  5, 32'hC0000000, 1};
        vt[4] = '{5, 6, 32'h40800000, 1'b0, 63, 32'h40000000, 0};
        vt[5] = '{5, 6, 32'h40000000, 1'b1, 63, 32'h00000000, 0};
        vt[6] = '{7, 7, 32'hBF800000, 1'b1, 63, 32'h3F800000, 0};
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < 7; i++) add_pipe[i] = 32'h0;

        program_resetn = 1'b0; clear_start = 1'b0; clear_rows = '0; clear_cols = '0;
        flush_req = 1'b0; stamp_negate = 1'b0; stamp_value = '0;
        stamp_valid = 1'b1; stamp_row = 6'd1; stamp_col = 6'd1; ground_node = 6'd63;
        repeat (3) @(negedge clk);
        #2;
        check("rst_ready", 32'(stamp_ready), 0);
        check("rst_flags", 32'({busy, clear_done, flush_done, matrix_wren_b}), 0);
        check("rst_skipped", 32'(skipped_count), 0);
        check("rst_addr", 32'({matrix_addr_a, matrix_addr_b}), 0);
        check("rst_data_b", matrix_data_b, 0);
        check("rst_adder", adder_data_a | adder_data_b, 0);
        program_resetn = 1'b1;
        #1;
        check("rel_ready", 32'(stamp_ready), 1);
        stamp_valid = 1'b0;
        @(negedge clk); #2;

        // Clear 3x4
        clr_log(); cd0 = cd_cnt; busy_err = 0;
        do_clear(3, 4, s);
        check("clr_count", wr_cyc_q.size(), 12);
        for (int i = 0; i < 12 && i < wr_cyc_q.size(); i++) begin
            check("clr_addr", 32'(wr_addr_q[i]), (i / 4) * 64 + i % 4);
            check("clr_cyc", wr_cyc_q[i], s + 1 + i);
            check("clr_data", wr_data_q[i], 0);
        end
        check("clr_busy", busy_err, 0);
        check("clr_done_cyc", cd_cyc, s + 13);
        repeat (3) @(negedge clk);
        #2;
        check("clr_done_once", cd_cnt - cd0, 1);

        // Empty clear region
        clr_log();
        do_clear(0, 4, s);
        check("clr0_done_cyc", cd_cyc, s + 1);
        check("clr0_writes", wr_cyc_q.size(), 0);

        // Same-address hazard
        offer(1, 2, 32'h3F800000, 1'b0, w, acc[0]);
        check("haz_first_wait", w, 0);
        offer(1, 2, 32'h3F000000, 1'b0, w, acc[1]);
        check("haz_second_wait", w, T);
        check("haz_spacing", acc[1] - acc[0], T + 1);
        do_flush();
        check("haz_word66", mem[66], 32'h3FC00000);

        // Independent addresses, back to back
        clr_log();
        offer(1, 0, 32'h40000000, 1'b0, w, acc[0]);
        offer(1, 1, 32'h40000000, 1'b0, w, acc[1]);
        offer(2, 0, 32'h40000000, 1'b0, w, acc[2]);
        offer(2, 1, 32'h40000000, 1'b0, w, acc[3]);
        do_flush();
        for (int i = 1; i < 4; i++) check("ind_accept_cyc", acc[i], acc[0] + i);
        check("ind_writes", wr_cyc_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_cyc_q.size(); i++) begin
            check("ind_wr_cyc", wr_cyc_q[i], acc[i] + T);
            check("ind_wr_addr", 32'(wr_addr_q[i]), (i / 2 + 1) * 64 + i % 2);
            check("ind_word", mem[(i / 2 + 1) * 64 + i % 2], 32'h40000000);
        end
        if (wr_cyc_q.size() > 0) check("ind_flush_cyc", fd_cyc, wr_cyc_q[wr_cyc_q.size()-1] + 1);

        // Ground skip then negate
        clr_log();
        ground_node = 6'd0;
        stamp_row = 6'd0; stamp_col = 6'd3; stamp_value = 32'h3F800000; stamp_valid = 1'b1;
        #1;
        check("gnd_ready", 32'(stamp_ready), 1);
        check("gnd_no_read", 32'(matrix_addr_a), 0);
        @(negedge clk); #2;
        stamp_valid = 1'b0;
        exp_skip = 1;
        check("gnd_skipped", 32'(skipped_count), exp_skip);
        repeat (T + 2) @(negedge clk);
        #2;
        check("gnd_no_write", wr_cyc_q.size(), 0);
        offer(3, 3, 32'h3F800000, 1'b1, w, a);
        do_flush();
        check("neg_word195", mem[195], 32'hBF800000);

        // Vector table on words 326 and 455
        foreach (vt[i]) begin
            ground_node = 6'(vt[i].gnd);
            offer(vt[i].row, vt[i].col, vt[i].val, vt[i].neg, w, a);
            if (vt[i].skip != 0 && exp_skip < 255) exp_skip++;
            do_flush();
            check("vec_word", mem[vt[i].row * 64 + vt[i].col], vt[i].exp);
            check("vec_skipped", 32'(skipped_count), exp_skip);
        end
        ground_node = 6'd63;

        // Reset during the 5th clear write
        clr_log(); cd0 = cd_cnt;
        clear_rows = 6'd2; clear_cols = 6'd4; clear_start = 1'b1;
        @(negedge clk); #2;
        clear_start = 1'b0;
        for (k = 0; k < 30 && wr_cyc_q.size() < 5; k++) begin @(negedge clk); #2; end
        program_resetn = 1'b0;
        #1;
        check("rstclr_wren", 32'(matrix_wren_b), 0);
        exp_skip = 0;
        repeat (3) @(negedge clk);
        #2;
        program_resetn = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rstclr_no_done", cd_cnt - cd0, 0);
        check("rstclr_writes", wr_cyc_q.size(), 5);
        clr_log();
        do_clear(1, 2, s);
        check("rstclr_again_done", cd_cnt - cd0, 1);
        check("rstclr_again_writes", wr_cyc_q.size(), 2);

        // Ground stamp hitting an in-flight address is not stalled; counter saturates
        offer(1, 2, 32'h3F800000, 1'b0, w, a);
        ground_node = 6'd2;
        offer(1, 2, 32'h3F800000, 1'b0, w, a);
        check("gnd_no_stall", w, 0);
        exp_skip++;
        ground_node = 6'd0;
        for (int i = 0; i < 260; i++) begin
            offer(0, i % 8, 32'h3F800000, 1'b0, w, a);
            if (exp_skip < 255) exp_skip++;
        end
        check("skip_saturate", 32'(skipped_count), exp_skip);
        do_flush();
        check("gnd_word66", mem[66], 32'h40200000);

        // Randomized stamps on an 8x8 region
        do_clear(8, 8, s);
        for (int i = 0; i < 64; i++) ref_m[i] = 0.0;
        for (int i = 0; i < 300; i++) begin
            int  r  = $urandom_range(0, 7);
            int  c  = $urandom_range(0, 7);
            int  kv = int'($urandom_range(0, 16)) - 8;
            logic ng = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin @(negedge clk); #2; end
            offer(r, c, r2f(real'(kv)), ng, w, a);
            if (r != 0 && c != 0) ref_m[r * 8 + c] += ng ? -real'(kv) : real'(kv);
            else if (exp_skip < 255) exp_skip++;
        end
        do_flush();
        for (int i = 0; i < 64; i++) check("rand_word", mem[(i / 8) * 64 + i % 8], r2f(ref_m[i]));
        check("rand_skipped", 32'(skipped_count), exp_skip);
        check("rand_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/matrix_stamp_accumulator.md
Name: matrix_stamp_accumulator

Overview:
- Parametrised read-modify-write engine that adds MNA stamp values into the float_matrix RAM. It is the next-generation replacement for the hard-coded compute states inside generateEquations.
- Accepts a stream of (row, col, value) stamps over valid/ready, drops ground-referenced stamps, and pipelines through a shared external FP adder.
- Stalls on read-after-write address hazards.
- Also clears a rows x cols region of the matrix.

Parameters:
- DATA_W, 32, float word width (IEEE-754 single)
- IDX_W, 6, row/col index width
- ROW_STRIDE, 64, words per matrix row; addr = row*ROW_STRIDE + col
- ADDR_W, 12, matrix address width
- RAM_LAT, 1, cycles from port-A address to matrix_out_a valid
- ADD_LAT, 7, external adder latency in cycles

Ports:
- clk  in  1  clock
- program_resetn  in  1  asynchronous, active-low reset
- clear_start  in  1  pulse: begin clearing region
- clear_rows  in  IDX_W  rows to clear, sampled on clear_start
- clear_cols  in  IDX_W  columns to clear, sampled on clear_start
- clear_done  out  1  one-cycle pulse when clear completes
- stamp_valid  in  1  stamp offered
- stamp_ready  out  1  stamp accepted when valid&ready
- stamp_row  in  IDX_W  row index
- stamp_col  in  IDX_W  column index
- stamp_value  in  DATA_W  value to add
- stamp_negate  in  1  subtract instead of add
- ground_node  in  IDX_W  index whose row/col is dropped
- flush_req  in  1  pulse: drain pipeline
- flush_done  out  1  one-cycle pulse when pipeline empty
- busy  out  1  state!=IDLE or any entry in flight
- skipped_count  out  8  stamps dropped due to ground, saturating
- matrix_addr_a  out  ADDR_W  read address
- matrix_addr_b  out  ADDR_W  write address
- matrix_data_b  out  DATA_W  write data
- matrix_wren_b  out  1  write enable
- matrix_out_a  in  DATA_W  read data
- adder_data_a  out  DATA_W  adder operand a
- adder_data_b  out  DATA_W  adder operand b
- adder_out  in  DATA_W  adder result

Behaviour:
- Reset (async, program_resetn=0):
  - All outputs are 0 and state=IDLE.
  - All in-flight valid bits and counters are cleared; any in-flight updates are lost.
  - stamp_ready=0 while reset is asserted.
- States:
  - IDLE: accepts stamps.
    - clear_start is honoured only when the pipeline is empty; otherwise it is ignored.
    - flush_req moves to FLUSH.
    - clear_start wins over a same-cycle flush_req.
  - CLEAR:
    - Writes 0x00000000 via port B, one word per cycle, row-major: row 0..clear_rows-1, col 0..clear_cols-1.
    - After the last write, clear_done pulses and the state returns to IDLE.
    - clear_rows=0 or clear_cols=0: no writes; clear_done pulses the cycle after clear_start.
  - FLUSH: stamp_ready=0; when no entry is in flight, flush_done pulses and the state returns to IDLE.
- stamp_ready (combinational) = state==IDLE & !clear_start & !flush_req & !hazard.
- hazard: the incoming addr equals the addr of any in-flight entry, including the one being written this cycle.
  - RAM read-during-write returns old data, so the write cycle counts as in flight.
- Ground rule:
  - A handshake with stamp_row==ground_node or stamp_col==ground_node makes no RAM access and consumes no pipeline slot.
  - skipped_count increments by 1 and saturates at 255.
  - The ground check precedes the hazard check: ground stamps are never stalled.
- Pipeline (T=RAM_LAT+ADD_LAT), for a stamp accepted at cycle t:
  - matrix_addr_a=addr at t.
  - adder_data_a=matrix_out_a and adder_data_b=value at t+RAM_LAT; value has bit DATA_W-1 inverted if stamp_negate.
  - matrix_wren_b=1 with matrix_addr_b=addr and matrix_data_b=adder_out at t+T.
  - One stamp is accepted per cycle maximum; the pipeline is fully pipelined with a delay line of T+1 (valid, addr).
- Address width: row*ROW_STRIDE+col is truncated to ADDR_W. Indices beyond the matrix are not checked.
- Port B is driven only by the pipeline in IDLE/FLUSH and only by CLEAR in CLEAR; these never overlap.
- Port A has no write enable: the block never writes through port A.
- busy=0 only in IDLE with an empty delay line.

Test Plan:
- Reset check: hold program_resetn=0 with clk running -> all outputs 0, stamp_ready=0; release -> stamp_ready=1 the next cycle with stamp_valid=1, ground_node=63.
- Clear: clear_rows=3, clear_cols=4 -> 12 consecutive writes of 0x00000000 to addr 0..3, 64..67, 128..131, then a single clear_done pulse; busy=1 throughout.
- Hazard on same address: after clear, stamps (1,2,0x3F800000) and (1,2,0x3F000000) offered back-to-back.
  - Second stamp has ready=0 until the first write cycle has passed (T+1 cycles).
  - Word 66 = 0x3FC00000 after flush_done.
- Independent addresses: 4 stamps to (1,0),(1,1),(2,0),(2,1) with value 0x40000000 -> accepted on 4 consecutive cycles, 4 writes on consecutive cycles starting t+T, each word = 0x40000000.
  - flush_req after the last handshake -> flush_done one cycle after the last write.
- Ground skip and negate: ground_node=0; stamp (0,3) -> no read/write, skipped_count=1, ready stays 1.
  - Stamp (3,3,0x3F800000,negate=1) on a cleared matrix -> word 195 = 0xBF800000.
- Reset mid-clear: assert program_resetn=0 during the 5th clear write -> matrix_wren_b drops immediately and clear_done never pulses.
  - After release, a new clear_start completes normally.
